byte_class_tokenizer: RTL and testbench

//  Streaming hardware take_while: splits a byte stream into maximal runs of bytes

---
 rtl/byte_class_tokenizer.sv | 131 +++++++++++++
 tb/tb_byte_class_tokenizer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_class_tokenizer.sv
// byte_class_tokenizer: splits a byte stream into maximal same-class runs and emits
// one (class, length, offset) token per run through a one-entry output register.
module byte_class_tokenizer #(
    parameter int NUM_CLASS = 4,
    parameter int LEN_W = 16,
    parameter int OFF_W = 32,
    localparam int CLS_W = $clog2(NUM_CLASS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CLS_W-1:0] cfg_class,
    input  logic [7:0]       cfg_byte,
    input  logic             cfg_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [CLS_W-1:0] tok_class,
    output logic [LEN_W-1:0] tok_len,
    output logic [OFF_W-1:0] tok_off,
    output logic             tok_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [255:0]       bm_q [NUM_CLASS];
    logic [255:0]       bm_d [NUM_CLASS];
    logic [CLS_W-1:0]   cls_q, cls_d, tc_q, tc_d, bc;
    logic [LEN_W-1:0]   len_q, len_d, tl_q, tl_d;
    logic [OFF_W-1:0]   start_q, start_d, off_q, off_d, to_q, to_d;
    logic               tv_q, tv_d, free, acc, same;

    always_comb begin
        bc = CLS_W'(NUM_CLASS);
        for (int c = NUM_CLASS - 1; c >= 0; c--)
            if (bm_q[c][in_data]) bc = CLS_W'(c);
        bm_d = bm_q;
        for (int c = 0; c < NUM_CLASS; c++)
            if (cfg_we && cfg_class == CLS_W'(c)) bm_d[c][cfg_byte] = cfg_bit;
    end

    assign free      = ~tv_q | tok_ready;
    assign in_ready  = (state_q != FLUSH) & free;
    assign acc       = in_valid & in_ready;
    assign same      = (bc == cls_q) & (len_q != {LEN_W{1'b1}});
    assign tok_valid = tv_q;
    assign tok_class = tc_q;
    assign tok_len   = tl_q;
    assign tok_off   = to_q;
    assign tok_err   = tc_q == CLS_W'(NUM_CLASS);
    assign busy      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        len_d   = len_q;
        start_d = start_q;
        off_d   = off_q;
        tv_d    = tv_q & ~tok_ready;
        tc_d    = tc_q;
        tl_d    = tl_q;
        to_d    = to_q;
        if (state_q == FLUSH && free) begin
            tv_d    = 1'b1;
            tc_d    = cls_q;
            tl_d    = LEN_W'(1);
            to_d    = start_q;
            state_d = IDLE;
        end
        if (acc) begin
            off_d = in_last ? '0 : off_q + 1'b1;
            if (state_q == RUN && same) begin
                len_d = len_q + 1'b1;
                if (in_last) begin
                    tv_d    = 1'b1;
                    tc_d    = cls_q;
                    tl_d    = len_q + 1'b1;
                    to_d    = start_q;
                    state_d = IDLE;
                end
            end else begin
                // A class change or full run closes the old run; the byte opens a new one.
                if (state_q == RUN) begin
                    tv_d = 1'b1;
                    tc_d = cls_q;
                    tl_d = len_q;
                    to_d = start_q;
                end else if (in_last) begin
                    tv_d = 1'b1;
                    tc_d = bc;
                    tl_d = LEN_W'(1);
                    to_d = off_q;
                end
                cls_d   = bc;
                len_d   = LEN_W'(1);
                start_d = off_q;
                state_d = in_last ? (state_q == RUN ? FLUSH : IDLE) : RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int c = 0; c < NUM_CLASS; c++) bm_q[c] <= '0;
            cls_q   <= '0;
            len_q   <= '0;
            start_q <= '0;
            off_q   <= '0;
            tv_q    <= 1'b0;
            tc_q    <= '0;
            tl_q    <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            bm_q    <= bm_d;
            cls_q   <= cls_d;
            len_q   <= len_d;
            start_q <= start_d;
            off_q   <= off_d;
            tv_q    <= tv_d;
            tc_q    <= tc_d;
            tl_q    <= tl_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: tb/tb_byte_class_tokenizer.sv
// tb_byte_class_tokenizer: directed stream tests with an expected-token queue
// checked whenever the DUT hands over a token.
module tb_byte_class_tokenizer;
    localparam int NC = 4;
    localparam int LW = 2;
    localparam int OW = 32;
    localparam int CW = 3;

    typedef struct {
        logic [31:0] c;
        logic [31:0] l;
        logic [31:0] o;
    } tok_t;

    logic          clk = 0;
    logic          rst = 1;
    logic          cfg_we = 0;
    logic [CW-1:0] cfg_class = 0;
    logic [7:0]    cfg_byte = 0;
    logic          cfg_bit = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [7:0]    in_data = 0;
    logic          in_last = 0;
    logic          tok_valid;
    logic          tok_ready = 1;
    logic [CW-1:0] tok_class;
    logic [LW-1:0] tok_len;
    logic [OW-1:0] tok_off;
    logic          tok_err;
    logic          busy;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    tok_t q[$];

    byte_class_tokenizer #(.NUM_CLASS(NC), .LEN_W(LW), .OFF_W(OW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_class(cfg_class),
        .cfg_byte(cfg_byte), .cfg_bit(cfg_bit), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_class(tok_class),
        .tok_len(tok_len), .tok_off(tok_off), .tok_err(tok_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    task automatic expect_tok(input int c, input int l, input int o);
        tok_t t;
        t.c = c;
        t.l = l;
        t.o = o;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (!rst && tok_valid && tok_ready) begin
            if (q.size() == 0) check("unexpected_token", 1, 0);
            else begin
                tok_t e;
                e = q.pop_front();
                check("tok_class", tok_class, e.c);
                check("tok_len", tok_len, e.l);
                check("tok_off", tok_off, e.o);
                check("tok_err", tok_err, e.c == NC);
            end
        end
    end

    task automatic cfg(input int c, input int b);
        cfg_we = 1;
        cfg_class = CW'(c);
        cfg_byte = 8'(b);
        cfg_bit = 1;
        @(posedge clk);
        #1;
        cfg_we = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int n = 0;
        in_valid = 1;
        in_data = b;
        in_last = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || tok_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", n < 50, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("rst_tok_valid", tok_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tok_len", tok_len, 0);
        check("rst_tok_off", tok_off, 0);
        check("rst_tok_class", tok_class, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 0;
        // T2: empty bitmaps -> one unmatched token
        expect_tok(NC, 2, 0);
        send(8'h41, 0);
        send(8'h42, 1);
        drain();
        // T1: letters vs digits; class2 also claims 'a' but class0 wins
        for (int b = "a"; b <= "z"; b++) cfg(0, b);
        for (int b = "0"; b <= "9"; b++) cfg(1, b);
        cfg(2, "a");
        expect_tok(0, 2, 0);
        expect_tok(1, 2, 2);
        send("a", 0);
        send("b", 0);
        check("t1_busy_run", busy, 1);
        send("1", 0);
        send("2", 1);
        check("t1_latency_valid", tok_valid, 1);
        check("t1_idle", busy, 0);
        drain();
        // T3: trailing different byte forces FLUSH
        do_reset();
        cfg(0, "a");
        expect_tok(0, 2, 0);
        expect_tok(NC, 1, 2);
        send("a", 0);
        send("a", 0);
        send("b", 1);
        check("t3_flush_in_ready", in_ready, 0);
        check("t3_flush_busy", busy, 1);
        @(posedge clk);
        #1;
        check("t3_after_flush_busy", busy, 0);
        drain();
        // T4: runs split at max length 3
        cfg(0, "x");
        expect_tok(0, 3, 0);
        expect_tok(0, 2, 3);
        for (int i = 0; i < 5; i++) send("x", i == 4);
        drain();
        // T5: consumer stall holds the token and back-pressures input
        cfg(1, "1");
        tok_ready = 0;
        expect_tok(0, 2, 0);
        expect_tok(1, 2, 2);
        expect_tok(0, 1, 4);
        send("a", 0);
        send("a", 0);
        send("1", 0);
        in_valid = 1;
        in_data = "1";
        in_last = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_in_ready_low", in_ready, 0);
            check("t5_hold_valid", tok_valid, 1);
            check("t5_hold_len", tok_len, 2);
            check("t5_hold_off", tok_off, 0);
            @(posedge clk);
            #1;
        end
        tok_ready = 1;
        send("1", 0);
        send("a", 1);
        drain();
        // T6: reset mid-run discards the partial run
        send("a", 0);
        send("a", 0);
        send("a", 0);
        rst = 1;
        #1;
        check("t6_rst_valid", tok_valid, 0);
        check("t6_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 0;
        check("t6_post_rst_valid", tok_valid, 0);
        cfg(2, "z");
        expect_tok(2, 1, 0);
        send("z", 1);
        drain();
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
